ifu_prefetch: RTL and testbench
===============================

// Module: ifu_prefetch
// PURPOSE
//   Next-generation instruction fetch unit: owns the fetch PC and a DEPTH-entry prefetch queue.
//   - Issues in-order requests to the instruction memory bus.
//   - Pairs each returned word with its PC and hands {pc, inst} to decode over valid/ready.
//   - Supports hold (stall issue) and flush/redirect (jump), discarding in-flight stale responses.
//   Sits between pc/branch control and the id stage, replacing the pass-through fetch path.
// PARAMETERS
//   ADDR_W    32     fetch address width
//   DATA_W    32     instruction word width
//   DEPTH     4      prefetch entries (power of 2, >=2); also max requests in flight
//   RESET_PC  'h0    fetch PC after reset
//   PC_INC    4      byte increment per fetch
// PORTS
//   clk               in   1       core clock
//   rst_n             in   1       asynchronous active-low reset
//   ifu_flush_i       in   1       redirect: drop all queued/in-flight work
//   ifu_flush_pc_i    in   ADDR_W  new fetch PC when ifu_flush_i=1
//   ifu_hold_i        in   1       suppress new requests (queue still drains)
//   ifu_req_valid_o   out  1       fetch request valid
//   ifu_req_addr_o    out  ADDR_W  fetch address (= current fetch PC)
//   ifu_req_ready_i   in   1       bus accepts request
//   ifu_rsp_valid_i   in   1       instruction word returned (in order, >=1 cycle after accept)
//   ifu_rsp_data_i    in   DATA_W  returned instruction word
//   ifu_inst_valid_o  out  1       head entry holds pc+inst for decode
//   ifu_pc_o          out  ADDR_W  PC of head entry
//   ifu_inst_data_o   out  DATA_W  instruction of head entry
//   ifu_inst_ready_i  in   1       decode consumes head entry
// BEHAVIOUR
//   - Reset (async, rst_n=0): fetch PC=RESET_PC; queue empty; drop_cnt=0.
//     Outputs: req_valid=0, inst_valid=0, pc_o=0, inst_data_o=0.
//   - Queue entry = {pc, data, filled}. Pointers: wr (alloc), fill, rd (head); each wraps mod DEPTH.
//   - Issue: req_valid_o = !hold && !flush && used<DEPTH, where used = allocated entries.
//     On req_valid&&req_ready: allocate entry at wr with pc=fetch PC, filled=0; wr++; fetch PC += PC_INC (wraps at 2^ADDR_W).
//   - Response: if drop_cnt>0, discard and drop_cnt--.
//     Otherwise write data into entry at fill, set filled=1, fill++.
//     A response with no unfilled entry and drop_cnt=0 is a protocol error: assertion only, ignored.
//   - Deliver: inst_valid_o = head allocated && filled; pc_o/inst_data_o driven from head (0 when invalid).
//     On inst_valid&&inst_ready: free head, rd++. Latency: response in cycle N -> inst_valid_o in N+1.
//   - Same-cycle alloc+free keeps used constant. Full queue (used=DEPTH) blocks issue only, never responses.
//   - Flush (priority over all):
//     - req_valid_o forced 0 that cycle.
//     - All entries freed; pointers reset to 0.
//     - fetch PC <= flush_pc_i.
//     - drop_cnt <= issued-but-unanswered count, excluding any response arriving that same cycle (that response is discarded).
//     - inst_ready in the flush cycle has no effect. Next cycle: issue from flush_pc_i if !hold.
//   - Hold: issue stops next evaluation; outstanding responses still fill; decode still drains.
//   - Flush during hold: PC updated, issue resumes from flush_pc_i when hold drops.
//   - drop_cnt>0 does not block issue. New responses are matched only after drop_cnt returns to 0 (in-order bus).
//   - Reset mid-operation: immediate return to reset state; bus responses after reset are not tracked.
// STRUCTURE
//   - define.v adds:
//     - `IFU_PC_INC
//     - `IFU_DEPTH_DEFAULT
//     - `PORT_ADDR_WIDTH / `PORT_DATA_WIDTH, reused for ADDR_W/DATA_W defaults
//   - Sub-module ifu_pf_queue: entry array, wr/fill/rd pointers, used count, clear input.
//   - ifu_prefetch keeps the fetch PC, issue logic, drop counter and flush sequencing.
// TESTING
//   1. Reset, no hold, ready=1, memory latency 1, inst_ready=1: addresses 0,4,8,... issued back-to-back;
//      decode sees pc 0 / inst at mem[0] two cycles after first accept, then one per cycle.
//   2. inst_ready=0, DEPTH=4: exactly 4 requests accepted, then req_valid_o=0.
//      Raise inst_ready: entries drain in order 0,4,8,C and issue resumes at 0x10.
//   3. Latency 3, flush to 0x100 with 2 responses in flight: both responses discarded (never on inst_valid_o);
//      first delivered pc=0x100 with mem[0x100].
//   4. Flush in the same cycle as a response and an inst handshake:
//      response dropped, head not double-freed, queue empty next cycle, req_addr_o=flush_pc.
//   5. hold=1 for 5 cycles with 3 in flight: no new requests; 3 entries delivered; issue resumes at the next sequential PC.
//   6. rst_n pulsed low mid-stream: all outputs 0 asynchronously; first request after release is RESET_PC.

Source files
------------

// File: rtl/ifu_prefetch_pkg.sv
// ifu_prefetch_pkg: shared widths and defaults for the instruction fetch unit
package ifu_prefetch_pkg;
   localparam int PORT_ADDR_WIDTH   = 32;
   localparam int PORT_DATA_WIDTH   = 32;
   localparam int IFU_DEPTH_DEFAULT = 4;
   localparam int IFU_PC_INC        = 4;
   // headroom for stale responses piling up across back-to-back redirects
   localparam int IFU_DROP_EXTRA    = 4;
endpackage

// File: rtl/ifu_prefetch_if.sv
// ifu_prefetch_if: redirect/hold control, memory bus and decode handshake of the fetch unit
interface ifu_prefetch_if
   import ifu_prefetch_pkg::*;
#(
   parameter int ADDR_W = PORT_ADDR_WIDTH,
   parameter int DATA_W = PORT_DATA_WIDTH
) ();
   logic              flush;
   logic [ADDR_W-1:0] flush_pc;
   logic              hold;
   logic              req_valid;
   logic [ADDR_W-1:0] req_addr;
   logic              req_ready;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              inst_valid;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] inst_data;
   logic              inst_ready;
   modport master (
      input  flush, flush_pc, hold, req_ready, rsp_valid, rsp_data, inst_ready,
      output req_valid, req_addr, inst_valid, pc, inst_data
   );
   modport slave (
      output flush, flush_pc, hold, req_ready, rsp_valid, rsp_data, inst_ready,
      input  req_valid, req_addr, inst_valid, pc, inst_data
   );
endinterface

// File: rtl/ifu_pf_queue.sv
// ifu_pf_queue: prefetch entries with separate alloc, fill and read pointers
module ifu_pf_queue #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              alloc,
   input  logic [ADDR_W-1:0] alloc_pc,
   input  logic              fill,
   input  logic [DATA_W-1:0] fill_data,
   input  logic              pop,
   output logic [CNT_W-1:0]  used,
   output logic [CNT_W-1:0]  unfilled,
   output logic              head_valid,
   output logic [ADDR_W-1:0] head_pc,
   output logic [DATA_W-1:0] head_data
);
   logic [ADDR_W-1:0] pc_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DEPTH-1:0]  filled_q;
   logic [PTR_W-1:0]  wr_ptr, fill_ptr, rd_ptr;
   assign head_valid = used != '0 && filled_q[rd_ptr];
   assign head_pc    = head_valid ? pc_q[rd_ptr] : '0;
   assign head_data  = head_valid ? data_q[rd_ptr] : '0;
   always_ff @(posedge clk) begin
      if (alloc && !clear) pc_q[wr_ptr] <= alloc_pc;
      if (fill && !clear) data_q[fill_ptr] <= fill_data;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         fill_ptr <= '0;
         rd_ptr   <= '0;
         used     <= '0;
         unfilled <= '0;
         filled_q <= '0;
      end else if (clear) begin
         wr_ptr   <= '0;
         fill_ptr <= '0;
         rd_ptr   <= '0;
         used     <= '0;
         unfilled <= '0;
         filled_q <= '0;
      end else begin
         // alloc and fill never target the same slot: fill only touches already-allocated entries
         if (alloc) begin
            filled_q[wr_ptr] <= 1'b0;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (fill) begin
            filled_q[fill_ptr] <= 1'b1;
            fill_ptr           <= fill_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         used     <= used + CNT_W'(alloc) - CNT_W'(pop);
         unfilled <= unfilled + CNT_W'(alloc) - CNT_W'(fill);
      end
   end
endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: fetch PC, in-order request issue, stale-response dropping and redirect handling
module ifu_prefetch
   import ifu_prefetch_pkg::*;
#(
   parameter int              ADDR_W   = PORT_ADDR_WIDTH,
   parameter int              DATA_W   = PORT_DATA_WIDTH,
   parameter int              DEPTH    = IFU_DEPTH_DEFAULT,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int              PC_INC   = IFU_PC_INC
) (
   input logic            clk,
   input logic            rst_n,
   ifu_prefetch_if.master bus
);
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int DROP_W = CNT_W + IFU_DROP_EXTRA;
   logic [ADDR_W-1:0] fetch_pc;
   logic [DROP_W-1:0] drop_cnt, in_flight;
   logic [CNT_W-1:0]  used, unfilled;
   logic              issue, fill, pop, rsp_used;
   assign bus.req_valid = rst_n && !bus.hold && !bus.flush && used < CNT_W'(DEPTH);
   assign bus.req_addr  = fetch_pc;
   assign issue         = bus.req_valid && bus.req_ready;
   assign fill          = bus.rsp_valid && !bus.flush && drop_cnt == '0 && unfilled != '0;
   assign pop           = bus.inst_valid && bus.inst_ready && !bus.flush;
   // a response landing in the flush cycle retires one outstanding request on its own
   assign rsp_used      = bus.rsp_valid && (drop_cnt != '0 || unfilled != '0);
   assign in_flight     = drop_cnt + DROP_W'(unfilled) - DROP_W'(rsp_used);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         drop_cnt <= '0;
      end else if (bus.flush) begin
         fetch_pc <= bus.flush_pc;
         drop_cnt <= in_flight;
      end else begin
         if (issue) fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
         if (bus.rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
      end
   end
   ifu_pf_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_queue (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (bus.flush),
      .alloc     (issue),
      .alloc_pc  (fetch_pc),
      .fill      (fill),
      .fill_data (bus.rsp_data),
      .pop       (pop),
      .used      (used),
      .unfilled  (unfilled),
      .head_valid(bus.inst_valid),
      .head_pc   (bus.pc),
      .head_data (bus.inst_data)
   );
   rsp_tracked: assert property (@(posedge clk) disable iff (!rst_n)
      bus.rsp_valid && !bus.flush && drop_cnt == '0 |-> unfilled != '0);
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: randomized bus/decode traffic checked against a transaction-level fetch model
module tb_ifu_prefetch;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int DEPTH = 4;
   localparam logic [31:0] RST_PC = 32'h0;
   typedef struct {logic [31:0] pc; bit filled;} ent_t;
   typedef struct {logic [31:0] addr; bit stale; int due;} txn_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   ifu_prefetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   ifu_prefetch #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(RST_PC), .PC_INC(4)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );
   ent_t mq[$];
   txn_t bq[$];
   logic [31:0] ref_pc;
   int cyc = 0;
   int total = 0;
   int bad = 0;
   int p_hold, p_flush, p_ready, p_take, max_lat;
   function automatic logic [31:0] mem(logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   task automatic idle_inputs();
      bus.hold = 1'b1;
      bus.flush = 1'b0;
      bus.flush_pc = '0;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_data = '0;
      bus.inst_ready = 1'b0;
   endtask
   task automatic check_reset_outputs();
      check("rst_req_valid", 32'(bus.req_valid), 32'h0);
      check("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
      check("rst_pc", bus.pc, 32'h0);
      check("rst_inst_data", bus.inst_data, 32'h0);
      check("rst_req_addr", bus.req_addr, RST_PC);
   endtask
   task automatic pulse_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      idle_inputs();
      #1 check_reset_outputs();
      mq.delete();
      bq.delete();
      ref_pc = RST_PC;
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic step();
      bit rv, iv, rsp, acc;
      txn_t t;
      @(negedge clk);
      cyc++;
      bus.hold = $urandom_range(99) < p_hold;
      bus.flush = $urandom_range(99) < p_flush;
      bus.flush_pc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
      bus.req_ready = $urandom_range(99) < p_ready;
      bus.inst_ready = $urandom_range(99) < p_take;
      rsp = bq.size() > 0 && bq[0].due <= cyc;
      bus.rsp_valid = rsp;
      bus.rsp_data = $urandom;
      if (rsp) bus.rsp_data = mem(bq[0].addr);
      rv = !bus.hold && !bus.flush && mq.size() < DEPTH;
      iv = mq.size() > 0 && mq[0].filled;
      #1;
      check("req_valid", 32'(bus.req_valid), 32'(rv));
      if (rv) check("req_addr", bus.req_addr, ref_pc);
      check("inst_valid", 32'(bus.inst_valid), 32'(iv));
      check("pc", bus.pc, iv ? mq[0].pc : 32'h0);
      check("inst_data", bus.inst_data, iv ? mem(mq[0].pc) : 32'h0);
      acc = rv && bus.req_ready;
      if (rsp) begin
         t = bq.pop_front();
         if (!t.stale && !bus.flush)
            for (int i = 0; i < mq.size(); i++)
               if (!mq[i].filled) begin
                  mq[i].filled = 1'b1;
                  break;
               end
      end
      if (bus.flush) begin
         mq.delete();
         foreach (bq[i]) bq[i].stale = 1'b1;
         ref_pc = bus.flush_pc;
      end else begin
         if (iv && bus.inst_ready) void'(mq.pop_front());
         if (acc) begin
            mq.push_back('{ref_pc, 1'b0});
            bq.push_back('{ref_pc, 1'b0, cyc + int'($urandom_range(max_lat, 1))});
            ref_pc += 32'd4;
         end
      end
   endtask
   task automatic run(int n, int h, int f, int r, int k, int l);
      p_hold = h;
      p_flush = f;
      p_ready = r;
      p_take = k;
      max_lat = l;
      for (int i = 0; i < n; i++) step();
   endtask
   initial begin
      idle_inputs();
      ref_pc = RST_PC;
      #12 check_reset_outputs();
      @(negedge clk);
      rst_n = 1'b1;
      run(100, 0, 0, 100, 100, 1);
      run(60, 0, 0, 100, 0, 1);
      run(40, 0, 0, 100, 100, 1);
      run(400, 10, 5, 70, 60, 3);
      run(300, 30, 10, 50, 50, 4);
      pulse_reset();
      run(500, 15, 8, 80, 70, 2);
      pulse_reset();
      run(800, 20, 15, 60, 40, 4);
      run(300, 5, 20, 100, 100, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
